// File: rtl/cobra_disp_pkg.sv
// Shared types and constants for the Cobra hexadecimal display output stage.
package cobra_disp_pkg;

  // Per-slot phase: anodes held off during GUARD, one digit lit during DRIVE.
  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low segments, bit6=g .. bit0=a, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
  import cobra_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for the nibble.
  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/cobra_hex_display.sv
// Cobra OUT-bus display driver: shadows the CPU output word and scans it onto an
// 8-digit multiplexed common-anode seven-segment display with guard blanking,
// leading-zero suppression and a fresh-value decimal point on digit 0.
module cobra_hex_display
  import cobra_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned GUARD         = 4,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] VALUE,
  input  logic        HOLD,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        UPD
);

  localparam int unsigned    CntW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD - 1);

  disp_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     shadow_q, shadow_d;
  logic            fresh_q, fresh_d;
  logic            started_q, started_d;

  logic [7:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;
  logic        capture;
  logic        slot_end;
  logic        scan_wrap;
  logic        lead_blank;
  logic [31:0] shifted;
  logic [6:0]  seg_dec;

  assign capture   = !HOLD && (VALUE != shadow_q);
  assign slot_end  = (cnt_q == CntLast);
  assign scan_wrap = slot_end && (idx_q == 3'd7);
  // Current digit lands in the low nibble; the rest are the more significant digits.
  assign shifted    = shadow_q >> {idx_q, 2'b00};
  assign lead_blank = BLANK_LEADING && (idx_q != 3'd0) && (shifted == 32'd0);

  hex7seg u_hex7seg (
    .nibble (shifted[3:0]),
    .seg    (seg_dec)
  );

  // Next-state for shadow capture, slot counter, digit index and guard/drive FSM.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    state_d  = state_q;
    if (capture) begin
      shadow_d = VALUE;
    end
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
    unique case (state_q)
      ST_GUARD: if (cnt_q == GuardLast) state_d = ST_DRIVE;
      ST_DRIVE: if (slot_end) state_d = ST_GUARD;
      default:  state_d = ST_GUARD;
    endcase
  end

  // Fresh flag: armed on capture, survives one full scan that begins after it.
  always_comb begin
    fresh_d   = fresh_q;
    started_d = started_q;
    if (capture) begin
      fresh_d   = 1'b1;
      started_d = 1'b0;
    end else if (scan_wrap && fresh_q) begin
      if (started_q) begin
        fresh_d   = 1'b0;
        started_d = 1'b0;
      end else begin
        started_d = 1'b1;
      end
    end
  end

  // Output decode from the current state; registered below for glitch-free pins.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state_q == ST_DRIVE && !lead_blank) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = seg_dec;
      dp_d  = !((idx_q == 3'd0) && fresh_q);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_q  <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      state_q   <= ST_GUARD;
      fresh_q   <= 1'b0;
      started_q <= 1'b0;
      AN        <= AN_OFF;
      SEG       <= SEG_BLANK;
      DP        <= 1'b1;
      UPD       <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      fresh_q   <= fresh_d;
      started_q <= started_d;
      AN        <= an_d;
      SEG       <= seg_d;
      DP        <= dp_d;
      UPD       <= capture;
    end
  end

endmodule

// File: tb/tb_cobra_hex_display.sv
// Directed self-checking bench for cobra_hex_display with SCAN_DIV=8, GUARD=2.
// k counts edges since the last reset edge; the output visible after edge k
// belongs to scan position p = k-1 (slot cnt = p%8, digit = (p/8)%8).
module tb_cobra_hex_display;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        HOLD = 1'b0;
  logic [31:0] VALUE = 32'd0;
  logic [7:0]  AN, AN_NB;
  logic [6:0]  SEG, SEG_NB;
  logic        DP, DP_NB, UPD, UPD_NB;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  cobra_hex_display #(
    .SCAN_DIV      (8),
    .GUARD         (2),
    .BLANK_LEADING (1'b1)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .VALUE (VALUE),
    .HOLD  (HOLD),
    .AN    (AN),
    .SEG   (SEG),
    .DP    (DP),
    .UPD   (UPD)
  );

  cobra_hex_display #(
    .SCAN_DIV      (8),
    .GUARD         (2),
    .BLANK_LEADING (1'b0)
  ) dut_nb (
    .CLK   (CLK),
    .RST   (RST),
    .VALUE (VALUE),
    .HOLD  (HOLD),
    .AN    (AN_NB),
    .SEG   (SEG_NB),
    .DP    (DP_NB),
    .UPD   (UPD_NB)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RST) k <= 0;
    else     k <= k + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    int lows [8];
    int p, c, d;
    logic [7:0] ea;
    logic [6:0] es;
    logic [31:0] v;
    v = 32'h12345678;
    RST = 1'b1;
    VALUE = v;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (AN !== 8'hFF || SEG !== 7'h7F || DP !== 1'b1 || UPD !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: AN=%h SEG=%b DP=%b UPD=%b, want FF 1111111 1 0",
                 i, AN, SEG, DP, UPD);
      end
    end
    RST = 1'b0;
    tick();
    n_checks++;
    if (UPD !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_upd_pulse: UPD=%b want 1", UPD);
    end
    tick();
    n_checks++;
    if (UPD !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_upd_single: UPD=%b want 0", UPD);
    end
    for (int i = 0; i < 8; i++) lows[i] = 0;
    for (int j = 0; j < 63; j++) begin
      p = k - 1;
      c = p % 8;
      d = (p / 8) % 8;
      ea = (c < 2) ? 8'hFF : an_tab[d];
      es = (c < 2) ? 7'h7F : seg_tab[(v >> (4 * d)) & 32'hF];
      for (int b = 0; b < 8; b++) if (AN[b] === 1'b0) lows[b]++;
      n_checks++;
      if (AN !== ea || SEG !== es || UPD !== 1'b0) begin
        n_fail++;
        $display("FAIL first_scan p=%0d: AN=%h SEG=%b UPD=%b, want %h %b 0", p, AN, SEG, UPD,
                 ea, es);
      end
      tick();
    end
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if (lows[b] != 6) begin
        n_fail++;
        $display("FAIL digit_on_time d%0d: low %0d cycles, want 6", b, lows[b]);
      end
    end
  endtask

  task automatic test_leading_blank();
    logic [31:0] vecs [2];
    logic [7:0]  lit [2];
    int p, c, d;
    logic [7:0] ea;
    logic [6:0] es;
    vecs[0] = 32'h0000002F; lit[0] = 8'h03;
    vecs[1] = 32'h00000000; lit[1] = 8'h01;
    for (int t = 0; t < 2; t++) begin
      VALUE = vecs[t];
      tick();
      tick();
      while (k % 64 != 1) tick();
      for (int j = 0; j < 64; j++) begin
        p = k - 1;
        c = p % 8;
        d = (p / 8) % 8;
        if (c >= 2 && lit[t][d]) begin
          ea = an_tab[d];
          es = seg_tab[(vecs[t] >> (4 * d)) & 32'hF];
        end else begin
          ea = 8'hFF;
          es = 7'h7F;
        end
        n_checks++;
        if (AN !== ea || SEG !== es) begin
          n_fail++;
          $display("FAIL leading_blank v=%h p=%0d: AN=%h SEG=%b, want %h %b", vecs[t], p, AN,
                   SEG, ea, es);
        end
        tick();
      end
    end
  endtask

  task automatic test_no_blank();
    int p, c, d;
    logic [7:0] ea;
    logic [6:0] es;
    logic [6:0] dig_seg [8];
    dig_seg[0] = 7'b0001110;
    dig_seg[1] = 7'b0100100;
    for (int i = 2; i < 8; i++) dig_seg[i] = 7'b1000000;
    VALUE = 32'h0000002F;
    tick();
    tick();
    while (k % 64 != 1) tick();
    for (int j = 0; j < 64; j++) begin
      p = k - 1;
      c = p % 8;
      d = (p / 8) % 8;
      ea = (c < 2) ? 8'hFF : an_tab[d];
      es = (c < 2) ? 7'h7F : dig_seg[d];
      n_checks++;
      if (AN_NB !== ea || SEG_NB !== es) begin
        n_fail++;
        $display("FAIL no_blank p=%0d: AN=%h SEG=%b, want %h %b", p, AN_NB, SEG_NB, ea, es);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    int p, c, d;
    VALUE = 32'h0000000A;
    tick();
    tick();
    HOLD = 1'b1;
    VALUE = 32'h0000000B;
    for (int j = 0; j < 80; j++) begin
      tick();
      p = k - 1;
      c = p % 8;
      d = (p / 8) % 8;
      n_checks++;
      if (UPD !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_no_upd p=%0d: UPD=%b want 0", p, UPD);
      end
      if (c >= 2 && d == 0) begin
        n_checks++;
        if (SEG !== 7'b0001000) begin
          n_fail++;
          $display("FAIL hold_digit0 p=%0d: SEG=%b want 0001000", p, SEG);
        end
      end
    end
    HOLD = 1'b0;
    tick();
    n_checks++;
    if (UPD !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release_upd: UPD=%b want 1", UPD);
    end
    tick();
    n_checks++;
    if (UPD !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release_single: UPD=%b want 0", UPD);
    end
    for (int j = 0; j < 64; j++) begin
      tick();
      p = k - 1;
      c = p % 8;
      d = (p / 8) % 8;
      if (c >= 2 && d == 0) begin
        n_checks++;
        if (SEG !== 7'b0000011) begin
          n_fail++;
          $display("FAIL hold_released_digit0 p=%0d: SEG=%b want 0000011", p, SEG);
        end
      end
    end
  endtask

  task automatic test_fresh();
    int base, r, last;
    logic edp;
    for (int ph = 0; ph < 2; ph++) begin
      for (int j = 0; j < 200; j++) tick();
      while (k % 64 != 28) tick();
      base = k - 28;
      VALUE = (ph == 0) ? 32'h00001234 : 32'h00005678;
      last = (ph == 0) ? 191 : 255;
      r = 28;
      while (r < last) begin
        tick();
        r = k - 1 - base;
        // Second capture lands mid slot 2 of the scan that is showing the dot.
        if (ph == 1 && k == base + 84) VALUE = 32'h00009ABC;
        edp = 1'b1;
        if (r >= 66 && r <= 71) edp = 1'b0;
        if (ph == 1 && r >= 130 && r <= 135) edp = 1'b0;
        n_checks++;
        if (DP !== edp) begin
          n_fail++;
          $display("FAIL fresh_dp ph%0d r=%0d: DP=%b want %b", ph, r, DP, edp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    VALUE = 32'h12345678;
    tick();
    tick();
    while (k % 64 != 37) tick();
    n_checks++;
    if (AN !== 8'hEF || SEG !== 7'b0011001) begin
      n_fail++;
      $display("FAIL pre_reset_digit4: AN=%h SEG=%b, want EF 0011001", AN, SEG);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++;
    if (AN !== 8'hFF || SEG !== 7'h7F || DP !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_blank: AN=%h SEG=%b DP=%b, want FF 1111111 1", AN, SEG, DP);
    end
    for (int j = 0; j < 2; j++) begin
      tick();
      n_checks++;
      if (AN !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset_mid_guard cyc %0d: AN=%h want FF", j, AN);
      end
    end
    tick();
    n_checks++;
    if (AN !== 8'hFE || SEG !== 7'b0000000) begin
      n_fail++;
      $display("FAIL reset_mid_first_drive: AN=%h SEG=%b, want FE 0000000", AN, SEG);
    end
  endtask

  initial begin
    test_reset();
    test_leading_blank();
    test_no_blank();
    test_hold();
    test_fresh();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cobra_hex_display.md
Name: cobra_hex_display

Overview:
- Output stage fed directly by the Cobra core's 32-bit OUT bus; drives an 8-digit common-anode multiplexed seven-segment display in hexadecimal.
- Captures the CPU output value into a shadow register and time-multiplexes one digit at a time.
- Inserts a blanking guard interval between digits to prevent ghosting.
- Provides leading-zero blanking and a "fresh value" decimal-point indicator.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; must be greater than GUARD + 1.
- GUARD, 4: cycles at the start of each slot with all anodes off.
- BLANK_LEADING, 1: 1 enables leading-zero blanking; 0 always shows all 8 digits.

Ports:
- CLK  in  1: system clock, shared with the Cobra core.
- RST  in  1: synchronous, active-high reset.
- VALUE  in  32: CPU output word (Cobra OUT).
- HOLD  in  1: 1 freezes the shadow register; VALUE changes are ignored.
- AN  out  8: digit enables, active-low; AN[0] is the least significant nibble.
- SEG  out  7: segments a..g on SEG[0]..SEG[6], active-low.
- DP  out  1: decimal point, active-low.
- UPD  out  1: one-cycle pulse when a new value is captured.

Behaviour:
- Clocking and reset:
  - One clock (CLK). Reset is synchronous and active-high (RST). All state is updated on the rising edge of CLK.
  - Reset values: shadow=0, idx=0, cnt=0, state=GUARD, fresh=0, AN=8'hFF, SEG=7'h7F, DP=1, UPD=0.
- Capture:
  - Each edge with HOLD=0 and VALUE!=shadow: shadow<=VALUE, fresh<=1, UPD<=1 (high for exactly the following cycle).
  - Otherwise UPD<=0.
  - Identical VALUE produces no UPD. HOLD=1 blocks capture entirely.
- Slot counter:
  - cnt counts 0..SCAN_DIV-1.
  - At cnt==SCAN_DIV-1: cnt<=0 and idx<=idx+1 (mod 8, wraps 7->0).
- FSM, per slot:
  - GUARD: active while cnt<GUARD. AN=8'hFF, SEG=7'h7F, DP=1.
  - DRIVE: active while cnt>=GUARD. AN has bit idx low (one-hot low); SEG = hex decode of shadow[4*idx+3 -: 4].
  - Transitions: GUARD->DRIVE when cnt==GUARD-1; DRIVE->GUARD on slot wrap.
- Output timing: AN, SEG and DP are registered, so they reflect shadow/idx as of the previous edge (1-cycle latency).
- A capture in mid-slot changes SEG on the next cycle; the slot is not restarted.
- Hex decode, active-low, bit6=g .. bit0=a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking:
  - If BLANK_LEADING=1 and idx>0 and shadow[31:4*idx]==0, then during DRIVE: AN=8'hFF, SEG=7'h7F.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Fresh indicator:
  - DP=0 during DRIVE of digit 0 while fresh=1.
  - fresh clears when idx wraps 7->0 after the first complete 8-slot scan that started after capture.
  - Implementation: a scan-start flag is set at the next idx==0 slot start; fresh clears at the following wrap.
  - A new capture while fresh=1 restarts this sequence.
- Reset mid-slot: all outputs are blank on the cycle after RST is sampled high. Scanning restarts at idx=0 in GUARD.

Decomposition:
- Package cobra_disp_pkg holds:
  - the state enum (ST_GUARD, ST_DRIVE);
  - the SEG_BLANK=7'h7F and AN_OFF=8'hFF constants;
  - the 16-entry hex segment constant table.
- One combinational sub-module, hex7seg (4-bit nibble in, 7-bit active-low segments out), instantiated once on the selected nibble.
- The top level holds the shadow register, counters, FSM and output registers.

Test Plan (SCAN_DIV=8, GUARD=2):
- Reset: hold RST for 3 cycles with VALUE=32'h12345678 -> AN=FF, SEG=7F, DP=1, UPD=0 throughout. After release, UPD pulses once (shadow 0 -> new value), then:
  - digit 0 shows 8 (0000000), digit 1 shows 7 (1111000), and so on;
  - AN pattern FE, FD, FB, ... FF between slots, each digit low for 6 of 8 cycles.
- Leading blank: VALUE=32'h0000002F -> only AN[0] (F, 0001110) and AN[1] (2, 0100100) ever go low; slots 2..7 keep AN=FF. VALUE=0 -> only digit 0 lit, showing 1000000.
- BLANK_LEADING=0 with VALUE=32'h0000002F -> all 8 digits driven, digits 2..7 show 1000000.
- HOLD: capture 32'hA, set HOLD=1, drive 32'hB -> no UPD pulse, digit 0 still 0001000. Release HOLD -> UPD pulses one cycle later, digit 0 shows 0000011.
- Fresh DP: capture a new value mid-slot 3 -> DP=0 during digit-0 DRIVE for exactly one full scan, DP=1 on the subsequent scan. A second capture during that scan extends it.
- Reset mid-slot: assert RST at cnt=5 of slot idx=4 -> next cycle AN=FF, SEG=7F, DP=1. After release, the first DRIVE is digit 0 starting 2 cycles later.
